// File: rtl/stage_ex_if.sv
// rtl/stage_ex_if.sv - ID/EX operand bundle and EX/MEM result bundle of the execute stage
// Signals:
//   ID/EX side  : busa_in, busb_in, funct3_in, imm_in, op_in, pc_in, rd_in (driven by master)
//   EX/MEM side : alu_out, busb_out, funct3_out, op_out, rd_out, branch_taken, branch_target
//   stall_ex    : combinational hold request back to IF/ID and ID/EX
// Modports: master = upstream pipeline / bench, slave = stage_ex.
interface stage_ex_if;
  logic [31:0] busa_in;
  logic [31:0] busb_in;
  logic [2:0]  funct3_in;
  logic [31:0] imm_in;
  logic [6:0]  op_in;
  logic [31:0] pc_in;
  logic [4:0]  rd_in;
  logic        stall_ex;
  logic [31:0] alu_out;
  logic [31:0] busb_out;
  logic [2:0]  funct3_out;
  logic [6:0]  op_out;
  logic [4:0]  rd_out;
  logic        branch_taken;
  logic [31:0] branch_target;

  modport master (
    output busa_in, busb_in, funct3_in, imm_in, op_in, pc_in, rd_in,
    input  stall_ex, alu_out, busb_out, funct3_out, op_out, rd_out,
           branch_taken, branch_target
  );

  modport slave (
    input  busa_in, busb_in, funct3_in, imm_in, op_in, pc_in, rd_in,
    output stall_ex, alu_out, busb_out, funct3_out, op_out, rd_out,
           branch_taken, branch_target
  );
endinterface

// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - RV32IM execute stage with iterative mul/div and EX/MEM register
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   ex  : stage_ex_if.slave (ID/EX inputs, EX/MEM registered outputs, stall_ex)
// Single-cycle ops land in the output register one edge after they appear.
// M ops occupy an IDLE->MUL/DIV->DONE sequence; the result is written on the
// edge leaving DONE and the output register carries bubbles until then.
module stage_ex #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input logic     clk,
  input logic     rst,
  stage_ex_if.slave ex
);
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         CW        = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_next;

  logic [2*XLEN-1:0] acc;       // MUL: {hi, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
  logic              md_neg_a, md_neg_b, md_zero;
  logic [2:0]        md_f3;
  logic [4:0]        md_rd;
  logic [6:0]        md_op;
  logic [CW-1:0]     count;
  logic              stall;

  wire is_m = (ex.op_in == OP_OP) && ex.imm_in[5];

  // FSM next state and stall
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: if (is_m) begin
        stall      = 1'b1;
        state_next = ex.funct3_in[2] ? DIV : MUL;
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (count == CNT_LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ex.stall_ex = stall;

  // Operand signedness: MULH/MULHSU sign rs1, MULH signs rs2, DIV/REM sign both.
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  always_comb begin
    sgn_a = ex.funct3_in[2] ? !ex.funct3_in[0]
                            : (ex.funct3_in[1:0] == 2'b01 || ex.funct3_in[1:0] == 2'b10);
    sgn_b = ex.funct3_in[2] ? !ex.funct3_in[0] : (ex.funct3_in[1:0] == 2'b01);
    mag_a = (sgn_a && ex.busa_in[XLEN-1]) ? -ex.busa_in : ex.busa_in;
    mag_b = (sgn_b && ex.busb_in[XLEN-1]) ? -ex.busb_in : ex.busb_in;
  end

  // One shift-add step and one restoring-divide step
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : '0)};
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_trial - {1'b0, opb};
    div_next  = (div_trial >= {1'b0, opb})
              ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
              : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Sign correction; remainder follows the dividend, so a zero divisor
  // naturally returns the original dividend.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, md_res;
  always_comb begin
    prod_s = (md_neg_a ^ md_neg_b) ? -acc : acc;
    quot_s = md_zero ? '1 : ((md_neg_a ^ md_neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
    rem_s  = md_neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (md_f3)
      3'b000:                 md_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         md_res = quot_s;
      default:                md_res = rem_s;
    endcase
  end

  // Single-cycle ALU and branch resolution
  logic [XLEN-1:0] alu_b, alu_res, pc_imm;
  logic [4:0]      shamt;
  logic            br_cond;
  always_comb begin
    alu_b  = (ex.op_in == OP_OP) ? ex.busb_in : ex.imm_in;
    shamt  = alu_b[4:0];
    pc_imm = ex.pc_in + ex.imm_in;
    case (ex.funct3_in)
      3'b000:  alu_res = (ex.op_in == OP_OP && ex.imm_in[10]) ? ex.busa_in - alu_b
                                                             : ex.busa_in + alu_b;
      3'b001:  alu_res = ex.busa_in << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(ex.busa_in) < $signed(alu_b)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, ex.busa_in < alu_b};
      3'b100:  alu_res = ex.busa_in ^ alu_b;
      3'b101:  alu_res = ex.imm_in[10] ? $unsigned($signed(ex.busa_in) >>> shamt)
                                       : ex.busa_in >> shamt;
      3'b110:  alu_res = ex.busa_in | alu_b;
      default: alu_res = ex.busa_in & alu_b;
    endcase
    case (ex.funct3_in)
      3'b000:  br_cond = ex.busa_in == ex.busb_in;
      3'b001:  br_cond = ex.busa_in != ex.busb_in;
      3'b100:  br_cond = $signed(ex.busa_in) <  $signed(ex.busb_in);
      3'b101:  br_cond = $signed(ex.busa_in) >= $signed(ex.busb_in);
      3'b110:  br_cond = ex.busa_in <  ex.busb_in;
      3'b111:  br_cond = ex.busa_in >= ex.busb_in;
      default: br_cond = 1'b0;
    endcase
  end

  // Next EX/MEM contents; zero is the bubble
  logic [XLEN-1:0] nx_alu, nx_busb, nx_target;
  logic [2:0]      nx_f3;
  logic [6:0]      nx_op;
  logic [4:0]      nx_rd;
  logic            nx_taken, pass;
  always_comb begin
    nx_alu = '0; nx_busb = '0; nx_target = '0; nx_f3 = '0;
    nx_op = '0; nx_rd = '0; nx_taken = 1'b0; pass = 1'b1;
    if (state == DONE) begin
      nx_alu = md_res; nx_f3 = md_f3; nx_op = md_op; nx_rd = md_rd;
      pass   = 1'b0;
    end else if (state == IDLE && !is_m) begin
      case (ex.op_in)
        OP_OP, OP_IMM:     nx_alu = alu_res;
        OP_LUI:            nx_alu = ex.imm_in;
        OP_AUIPC:          nx_alu = pc_imm;
        OP_LOAD, OP_STORE: nx_alu = ex.busa_in + ex.imm_in;
        OP_JAL: begin
          nx_alu = ex.pc_in + 32'd4; nx_target = pc_imm; nx_taken = 1'b1;
        end
        OP_JALR: begin
          nx_alu    = ex.pc_in + 32'd4;
          nx_target = (ex.busa_in + ex.imm_in) & ~32'd1;
          nx_taken  = 1'b1;
        end
        OP_BRANCH: begin
          nx_target = pc_imm; nx_taken = br_cond;
        end
        default: pass = 1'b0;  // bubble or unknown opcode
      endcase
      if (pass) begin
        nx_busb = ex.busb_in; nx_f3 = ex.funct3_in; nx_op = ex.op_in; nx_rd = ex.rd_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      opb      <= '0;
      md_neg_a <= 1'b0;
      md_neg_b <= 1'b0;
      md_zero  <= 1'b0;
      md_f3    <= '0;
      md_rd    <= '0;
      md_op    <= '0;
      count    <= '0;
      ex.alu_out       <= '0;
      ex.busb_out      <= '0;
      ex.funct3_out    <= '0;
      ex.op_out        <= '0;
      ex.rd_out        <= '0;
      ex.branch_taken  <= 1'b0;
      ex.branch_target <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (is_m) begin
          acc      <= {{XLEN{1'b0}}, mag_a};
          opb      <= mag_b;
          md_neg_a <= sgn_a && ex.busa_in[XLEN-1];
          md_neg_b <= sgn_b && ex.busb_in[XLEN-1];
          md_zero  <= (ex.busb_in == '0);
          md_f3    <= ex.funct3_in;
          md_rd    <= ex.rd_in;
          md_op    <= ex.op_in;
          count    <= '0;
        end
        MUL: begin acc <= mul_next; count <= count + 1'b1; end
        DIV: begin acc <= div_next; count <= count + 1'b1; end
        default: count <= '0;
      endcase
      ex.alu_out       <= nx_alu;
      ex.busb_out      <= nx_busb;
      ex.funct3_out    <= nx_f3;
      ex.op_out        <= nx_op;
      ex.rd_out        <= nx_rd;
      ex.branch_taken  <= nx_taken;
      ex.branch_target <= nx_target;
    end
  end
endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - directed self-checking bench for stage_ex
module tb_stage_ex;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  stage_ex_if bus ();

  stage_ex #(.XLEN(32), .MD_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd);
    bus.op_in = op; bus.funct3_in = f3; bus.busa_in = a; bus.busb_in = b;
    bus.imm_in = imm; bus.pc_in = pc; bus.rd_in = rd;
  endtask

  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rd);
    @(negedge clk);
    drive(op, f3, a, b, imm, pc, rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // M op: count stall cycles (bounded), confirm bubble during DONE, then check result.
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cnt = 0;
    apply(OP, f3, a, b, 32'h20, 32'h0, 5'd9);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.stall_ex) break;
      cnt++;
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, cnt, 33);
    check({tag, "_bubble"}, bus.alu_out, 32'h0);
    tick();
    check(tag, bus.alu_out, exp);
    check({tag, "_rd"}, {27'b0, bus.rd_out}, 32'd9);
  endtask

  initial begin
    drive(OP, 3'b000, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3);
    repeat (3) tick();
    check("rst_alu", bus.alu_out, 32'h0);
    check("rst_rd", {27'b0, bus.rd_out}, 32'h0);
    check("rst_op", {25'b0, bus.op_out}, 32'h0);
    check("rst_taken", {31'b0, bus.branch_taken}, 32'h0);
    check("rst_stall", {31'b0, bus.stall_ex}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    check("add", bus.alu_out, 32'd12);
    check("add_rd", {27'b0, bus.rd_out}, 32'd3);
    check("add_busb", bus.busb_out, 32'd7);

    apply(OP, 3'b000, 32'd3, 32'd5, 32'h400, 32'h0, 5'd4);
    tick();
    check("sub", bus.alu_out, 32'hFFFF_FFFE);

    apply(OPIMM, 3'b101, 32'h8000_0000, 32'h0, 32'h404, 32'h0, 5'd5);
    tick();
    check("srai", bus.alu_out, 32'hF800_0000);

    apply(OP, 3'b011, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd6);
    tick();
    check("sltu", bus.alu_out, 32'd1);

    apply(BRANCH, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h100, 5'd0);
    tick();
    check("bne_taken", {31'b0, bus.branch_taken}, 32'd1);
    check("bne_target", bus.branch_target, 32'h0000_00F0);
    check("bne_alu", bus.alu_out, 32'h0);

    apply(BRANCH, 3'b000, 32'd1, 32'd2, 32'h10, 32'h100, 5'd0);
    tick();
    check("beq_not_taken", {31'b0, bus.branch_taken}, 32'd0);

    apply(JALR, 3'b000, 32'h203, 32'h0, 32'h0, 32'h40, 5'd1);
    tick();
    check("jalr_target", bus.branch_target, 32'h202);
    check("jalr_link", bus.alu_out, 32'h44);
    check("jalr_taken", {31'b0, bus.branch_taken}, 32'd1);

    apply(7'b0, 3'b000, 32'd1, 32'd2, 32'h0, 32'h0, 5'd7);
    tick();
    check("bubble_alu", bus.alu_out, 32'h0);
    check("bubble_rd", {27'b0, bus.rd_out}, 32'h0);

    run_md("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_md("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_md("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("remu_z", 3'b111, 32'd10,        32'd0,         32'd10);
    run_md("divu_z", 3'b101, 32'd10,        32'd0,         32'hFFFF_FFFF);
    run_md("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_md("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);

    // Abort a DIV with reset partway through, then issue an ADD.
    apply(OP, 3'b100, 32'd100, 32'd3, 32'h20, 32'h0, 5'd8);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    drive(OP, 3'b000, 32'd20, 32'd22, 32'h0, 32'h0, 5'd2);
    tick();
    check("abort_stall", {31'b0, bus.stall_ex}, 32'h0);
    check("abort_alu", bus.alu_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_abort_add", bus.alu_out, 32'd42);
    check("post_abort_rd", {27'b0, bus.rd_out}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
